// File: rtl/minitb_ahb_arbiter.sv
// Round-robin arbiter sharing one AHB-lite master port among NUM_REQ requesters.
// One non-pipelined NONSEQ single transfer at a time, with per-phase hready timeout.
module minitb_ahb_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                          hclk,
   input  logic                          hreset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic                          err,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          busy,
   output logic [1:0]                    htrans,
   output logic [ADDR_WIDTH-1:0]         haddr,
   output logic                          hwrite,
   output logic [DATA_WIDTH-1:0]         hwdata,
   input  logic [DATA_WIDTH-1:0]         hrdata,
   input  logic                          hready
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10
   } state_t;

   state_t                 state_r, state_s;
   logic [IDX_W-1:0]       last_r, last_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic [NUM_REQ-1:0]     grant_r, grant_s;
   logic [NUM_REQ-1:0]     done_r, done_s;
   logic                   err_r, err_s;
   logic [DATA_WIDTH-1:0]  rdata_r, rdata_s;
   logic                   busy_r, busy_s;
   logic [1:0]             htrans_r, htrans_s;
   logic [ADDR_WIDTH-1:0]  haddr_r, haddr_s;
   logic                   hwrite_r, hwrite_s;
   logic [DATA_WIDTH-1:0]  hwdata_r, hwdata_s;
   logic [DATA_WIDTH-1:0]  wdata_r, wdata_s;

   logic [NUM_REQ-1:0]     elig_s;
   logic [IDX_W-1:0]       cand_s;
   logic [IDX_W-1:0]       win_idx_s;
   logic                   win_found_s;
   logic [NUM_REQ-1:0]     win_oh_s;
   logic [ADDR_WIDTH-1:0]  win_addr_s;
   logic                   win_write_s;
   logic [DATA_WIDTH-1:0]  win_wdata_s;
   logic                   abort_s;

   // Round-robin winner search starting after the last owner, plus winner command mux
   always_comb begin
      // the requester completing this cycle must not win straight back
      elig_s      = req & ~done_r;
      cand_s      = '0;
      win_idx_s   = '0;
      win_found_s = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s      = IDX_W'((int'(last_r) + k) % NUM_REQ);
         win_idx_s   = (!win_found_s && elig_s[cand_s]) ? cand_s : win_idx_s;
         win_found_s = win_found_s | elig_s[cand_s];
      end
      win_oh_s    = NUM_REQ'(win_found_s) << win_idx_s;
      win_addr_s  = '0;
      win_write_s = 1'b0;
      win_wdata_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_addr_s  = win_addr_s  | ({ADDR_WIDTH{win_oh_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
         win_write_s = win_write_s | (win_oh_s[i] & req_write[i]);
         win_wdata_s = win_wdata_s | ({DATA_WIDTH{win_oh_s[i]}} & req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Next-state and next-output logic for the IDLE/ADDR/DATA sequencer
   always_comb begin
      state_s  = state_r;
      last_s   = last_r;
      cnt_s    = cnt_r;
      grant_s  = grant_r;
      done_s   = '0;
      err_s    = 1'b0;
      rdata_s  = rdata_r;
      busy_s   = busy_r;
      htrans_s = htrans_r;
      haddr_s  = haddr_r;
      hwrite_s = hwrite_r;
      hwdata_s = hwdata_r;
      wdata_s  = wdata_r;
      // fires on the TIMEOUT-th consecutive low edge of the current phase
      abort_s  = (state_r != ST_IDLE) && !hready && (TIMEOUT != 0) && (cnt_r == CNT_LAST);

      if (abort_s) begin
         state_s  = ST_IDLE;
         htrans_s = HTRANS_IDLE;
         done_s   = grant_r;
         err_s    = 1'b1;
         rdata_s  = '0;
         grant_s  = '0;
         busy_s   = 1'b0;
         cnt_s    = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               htrans_s = HTRANS_IDLE;
               if (win_found_s) begin
                  state_s  = ST_ADDR;
                  last_s   = win_idx_s;
                  grant_s  = win_oh_s;
                  haddr_s  = win_addr_s;
                  hwrite_s = win_write_s;
                  wdata_s  = win_wdata_s;
                  htrans_s = HTRANS_NONSEQ;
                  busy_s   = 1'b1;
                  cnt_s    = '0;
               end else begin
                  state_s  = ST_IDLE;
               end
            end
            ST_ADDR: begin
               if (hready) begin
                  state_s  = ST_DATA;
                  htrans_s = HTRANS_IDLE;
                  hwdata_s = hwrite_r ? wdata_r : hwdata_r;
                  cnt_s    = '0;
               end else begin
                  cnt_s    = cnt_r + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (hready) begin
                  state_s  = ST_IDLE;
                  done_s   = grant_r;
                  rdata_s  = hwrite_r ? rdata_r : hrdata;
                  grant_s  = '0;
                  busy_s   = 1'b0;
                  cnt_s    = '0;
               end else begin
                  cnt_s    = cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_s  = ST_IDLE;
               htrans_s = HTRANS_IDLE;
               grant_s  = '0;
               busy_s   = 1'b0;
               cnt_s    = '0;
            end
         endcase
      end
   end

   // State and output registers; reset abandons any in-flight transfer silently
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_r  <= ST_IDLE;
         last_r   <= LAST_RST;
         cnt_r    <= '0;
         grant_r  <= '0;
         done_r   <= '0;
         err_r    <= 1'b0;
         rdata_r  <= '0;
         busy_r   <= 1'b0;
         htrans_r <= HTRANS_IDLE;
         haddr_r  <= '0;
         hwrite_r <= 1'b0;
         hwdata_r <= '0;
         wdata_r  <= '0;
      end else begin
         state_r  <= state_s;
         last_r   <= last_s;
         cnt_r    <= cnt_s;
         grant_r  <= grant_s;
         done_r   <= done_s;
         err_r    <= err_s;
         rdata_r  <= rdata_s;
         busy_r   <= busy_s;
         htrans_r <= htrans_s;
         haddr_r  <= haddr_s;
         hwrite_r <= hwrite_s;
         hwdata_r <= hwdata_s;
         wdata_r  <= wdata_s;
      end
   end

   assign grant  = grant_r;
   assign done   = done_r;
   assign err    = err_r;
   assign rdata  = rdata_r;
   assign busy   = busy_r;
   assign htrans = htrans_r;
   assign haddr  = haddr_r;
   assign hwrite = hwrite_r;
   assign hwdata = hwdata_r;

endmodule
